// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and decode helpers for the MEM stage.
package mem_access_stage_pkg;

  // Memory operation encodings carried down the pipeline from decode.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DATA_W = 32;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword accesses need an even address, word accesses a word-aligned one.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = lo[0];
      MEM_LW, MEM_SW:          mis = (lo != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; the store and load halves have independent inputs
// because stores are formed at issue time and loads at response time.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (st_op)
      MEM_SB: begin
        wstrb = 4'b0001 << st_lo;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        wstrb = st_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      MEM_SW: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
      default: ;
    endcase
  end

  // Pick the addressed lane from the read word and extend it to 32 bits.
  always_comb begin
    case (ld_lo)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_op)
      MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data = {24'h0, ld_byte};
      MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data = {16'h0, ld_half};
      MEM_LW:  ld_data = ld_raw;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/ack bus, stalls upstream while an
// access is outstanding, and hands the retired instruction to MEM_WB.
// Non-memory instructions pass straight through with no added latency.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        have_inst_i,
  input  logic [31:0] pc_i,
  input  logic        rf_we_i,
  input  logic [4:0]  wR_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] st_data_i,
  input  logic [3:0]  mem_op_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [31:0] wD_o,
  output logic [4:0]  wR_o,
  output logic [31:0] pc_o,
  output logic        have_inst_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [4:0]      wr_q;
  logic [31:0]     pc_q;
  logic            rf_we_q;
  logic [1:0]      lo_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic            is_mem;
  logic            is_mis;
  logic            issue;
  logic            timeout_hit;
  logic [3:0]      st_wstrb;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;

  assign is_mem      = have_inst_i && (op_is_load(mem_op_i) || op_is_store(mem_op_i));
  assign is_mis      = op_misaligned(mem_op_i, alu_i[1:0]);
  assign issue       = (state_q == ST_IDLE) && is_mem && !is_mis;
  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));

  mem_lane_align u_align (
    .st_op   (mem_op_i),
    .st_lo   (alu_i[1:0]),
    .st_data (st_data_i),
    .ld_op   (op_q),
    .ld_lo   (lo_q),
    .ld_raw  (rdata_q),
    .wstrb   (st_wstrb),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Latch the instruction and bus registers on issue; retire on ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      op_q        <= 4'h0;
      wr_q        <= 5'h0;
      pc_q        <= 32'h0;
      rf_we_q     <= 1'b0;
      lo_q        <= 2'b00;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_wstrb_o <= 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            cnt_q       <= '0;
            op_q        <= mem_op_i;
            wr_q        <= wR_i;
            pc_q        <= pc_i;
            rf_we_q     <= rf_we_i;
            lo_q        <= alu_i[1:0];
            err_q       <= 1'b0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= op_is_store(mem_op_i);
            bus_addr_o  <= {alu_i[31:2], 2'b00};
            bus_wdata_o <= st_wdata;
            bus_wstrb_o <= st_wstrb;
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            rdata_q   <= bus_rdata_i;
            bus_req_o <= 1'b0;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and MEM_WB-facing outputs; reset forces the control outputs low.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    have_inst_o = 1'b0;
    rf_we_o     = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    wD_o        = 32'h0;
    wR_o        = wr_q;
    pc_o        = pc_q;
    case (state_q)
      ST_IDLE: begin
        wR_o = wR_i;
        pc_o = pc_i;
        wD_o = alu_i;
        if (is_mem) begin
          if (is_mis) begin
            have_inst_o = 1'b1;
            misalign_o  = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = ST_BUSY;
          end
        end else begin
          have_inst_o = have_inst_i;
          rf_we_o     = rf_we_i && have_inst_i;
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (bus_ack_i || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        have_inst_o = 1'b1;
        rf_we_o     = rf_we_q && op_is_load(op_q) && !err_q;
        wD_o        = op_is_load(op_q) ? ld_data : 32'h0;
        bus_err_o   = err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      stall_o     = 1'b0;
      have_inst_o = 1'b0;
      rf_we_o     = 1'b0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: each instruction is expanded into the list of
// per-cycle outputs it must produce, and a single compare process checks the
// DUT against that list every cycle.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        have_inst_i;
  logic [31:0] pc_i;
  logic        rf_we_i;
  logic [4:0]  wR_i;
  logic [31:0] alu_i;
  logic [31:0] st_data_i;
  logic [3:0]  mem_op_i;
  logic        stall_o;
  logic        rf_we_o;
  logic [31:0] wD_o;
  logic [4:0]  wR_o;
  logic [31:0] pc_o;
  logic        have_inst_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  mem_access_stage #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .have_inst_i(have_inst_i), .pc_i(pc_i),
    .rf_we_i(rf_we_i), .wR_i(wR_i), .alu_i(alu_i), .st_data_i(st_data_i),
    .mem_op_i(mem_op_i), .stall_o(stall_o), .rf_we_o(rf_we_o), .wD_o(wD_o),
    .wR_o(wR_o), .pc_o(pc_o), .have_inst_o(have_inst_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, have, rf_we, mis, err, req;
    bit          chk_wd;
    logic [31:0] wd;
    bit          chk_ctl;
    logic [4:0]  wr;
    logic [31:0] pc;
    bit          chk_bus;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   req_cyc = 0;
  int   stall_cyc = 0;

  bit          lit_wd_en = 0;
  logic [31:0] lit_wd;
  bit          lit_bus_en = 0;
  logic [31:0] lit_addr, lit_wdata;
  logic [3:0]  lit_wstrb;
  logic        lit_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural rules for memory operations.
  function automatic bit is_ld(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit is_st(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit misal(input int op, input logic [31:0] a);
    if (op == 2 || op == 5 || op == 7) return a % 2 != 0;
    if (op == 3 || op == 8) return a % 4 != 0;
    return 0;
  endfunction

  function automatic logic [31:0] ld_val(input int op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * (a % 4))) & 32'hFF;
    h = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      2: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      3: return r;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input int op, input logic [31:0] a);
    if (op == 6) return 4'(1 << (a % 4));
    if (op == 7) return ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
    if (op == 8) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] st_word(input int op, input logic [31:0] d);
    if (op == 6) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 7) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Single compare point: one expected record per cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall", stall_o, e.stall);
      chk("have_inst", have_inst_o, e.have);
      chk("rf_we", rf_we_o, e.rf_we);
      chk("misalign", misalign_o, e.mis);
      chk("bus_err", bus_err_o, e.err);
      chk("bus_req", bus_req_o, e.req);
      if (e.chk_wd) chk("wD", wD_o, e.wd);
      if (e.chk_ctl) begin
        chk("wR", wR_o, e.wr);
        chk("pc", pc_o, e.pc);
      end
      if (e.chk_bus) begin
        chk("bus_addr", bus_addr_o, e.addr);
        chk("bus_we", bus_we_o, e.we);
        chk("bus_wstrb", bus_wstrb_o, e.wstrb);
        if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
      end
    end
  end

  // Cycle counters used by a few literal checks.
  always @(negedge clk) begin
    if (bus_req_o) req_cyc++;
    if (stall_o) stall_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_wd_check();
    if (lit_wd_en) begin
      @(negedge clk);
      chk("lit_wD", wD_o, lit_wd);
      lit_wd_en = 0;
    end
  endtask

  // Drive one instruction from IDLE until the stage is ready for the next.
  task automatic run_inst(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic rf, input logic [4:0] wr, input logic [31:0] pc,
                          input logic hv, input int ack_d, input logic [31:0] rd);
    exp_t e;
    int   nb;
    bit   acked, ld, st;
    ld = is_ld(int'(op));
    st = is_st(int'(op));
    mem_op_i = op; alu_i = a; st_data_i = d; rf_we_i = rf;
    wR_i = wr; pc_i = pc; have_inst_i = hv; bus_ack_i = 1'b0;
    e = '{default: '0};
    if (!hv || !(ld || st)) begin
      e.have = hv; e.rf_we = rf & hv;
      e.chk_wd = 1; e.wd = a;
      e.chk_ctl = 1; e.wr = wr; e.pc = pc;
      expq.push_back(e);
      lit_wd_check();
      step();
      return;
    end
    if (misal(int'(op), a)) begin
      e.have = 1; e.mis = 1;
      e.chk_ctl = 1; e.wr = wr; e.pc = pc;
      expq.push_back(e);
      step();
      return;
    end
    e.stall = 1;
    expq.push_back(e);
    step();
    acked = ack_d < TO;
    nb = acked ? ack_d + 1 : TO;
    for (int k = 0; k < nb; k++) begin
      e = '{default: '0};
      e.stall = 1; e.req = 1; e.chk_bus = 1;
      e.addr = a - (a % 4); e.we = st;
      e.wstrb = st_strb(int'(op), a); e.wdata = st_word(int'(op), d);
      if (acked && k == ack_d) begin
        bus_ack_i = 1'b1; bus_rdata_i = rd;
      end else begin
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
      end
      expq.push_back(e);
      if (lit_bus_en && k == 0) begin
        @(negedge clk);
        chk("lit_bus_addr", bus_addr_o, lit_addr);
        chk("lit_bus_we", bus_we_o, lit_we);
        chk("lit_bus_wstrb", bus_wstrb_o, lit_wstrb);
        if (lit_we) chk("lit_bus_wdata", bus_wdata_o, lit_wdata);
        lit_bus_en = 0;
      end
      step();
    end
    bus_ack_i = 1'b0;
    mem_op_i = 4'($urandom_range(0, 8)); alu_i = $urandom; st_data_i = $urandom;
    rf_we_i = 1'b1; wR_i = 5'($urandom); pc_i = $urandom; have_inst_i = 1'b1;
    e = '{default: '0};
    e.have = 1; e.rf_we = ld && rf && acked; e.err = !acked;
    e.chk_wd = e.rf_we; e.wd = ld_val(int'(op), a, rd);
    e.chk_ctl = 1; e.wr = wr; e.pc = pc;
    expq.push_back(e);
    lit_wd_check();
    step();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish want finish by %0t", $time);
    $fatal(1);
  end

  initial begin : main
    exp_t e;
    int          op, ack_d;
    logic [31:0] a, d, rd, pcv;
    logic        rf, hv;
    logic [4:0]  wr;

    rst = 1'b1; have_inst_i = 0; pc_i = 0; rf_we_i = 0; wR_i = 0; alu_i = 0;
    st_data_i = 0; mem_op_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    step();
    repeat (2) begin
      expq.push_back('{default: '0});
      step();
    end
    rst = 1'b0;

    lit_wd_en = 1; lit_wd = 32'h0000_1234;
    run_inst(MEM_NONE, 32'h1234, 32'h0, 1'b1, 5'd3, 32'h40, 1'b1, 0, 32'h0);

    stall_cyc = 0;
    lit_wd_en = 1; lit_wd = 32'hFFFF_FF80;
    lit_bus_en = 1; lit_addr = 32'h100; lit_we = 0; lit_wstrb = 4'h0; lit_wdata = 0;
    run_inst(MEM_LB, 32'h103, 32'h0, 1'b1, 5'd5, 32'h44, 1'b1, 1, 32'h80FF_FF7F);
    chk("lb_stall_cycles", stall_cyc, 3);

    lit_wd_en = 1; lit_wd = 32'h0000_0080;
    run_inst(MEM_LBU, 32'h103, 32'h0, 1'b1, 5'd6, 32'h48, 1'b1, 0, 32'h80FF_FF7F);

    lit_bus_en = 1; lit_addr = 32'h200; lit_we = 1; lit_wstrb = 4'hC; lit_wdata = 32'hABCD_ABCD;
    run_inst(MEM_SH, 32'h202, 32'h0000_ABCD, 1'b1, 5'd7, 32'h4C, 1'b1, 2, 32'h0);

    req_cyc = 0; stall_cyc = 0;
    run_inst(MEM_LW, 32'h301, 32'h0, 1'b1, 5'd8, 32'h50, 1'b1, 0, 32'h0);
    chk("misal_req_cycles", req_cyc, 0);
    chk("misal_stall_cycles", stall_cyc, 0);

    req_cyc = 0;
    run_inst(MEM_LW, 32'h304, 32'h0, 1'b1, 5'd9, 32'h54, 1'b1, 99, 32'h0);
    chk("timeout_req_cycles", req_cyc, TO);

    // Reset in the middle of an outstanding access.
    mem_op_i = MEM_LW; alu_i = 32'h400; have_inst_i = 1; rf_we_i = 1; bus_ack_i = 0;
    e = '{default: '0}; e.stall = 1;
    expq.push_back(e);
    step();
    e = '{default: '0}; e.stall = 1; e.req = 1; e.chk_bus = 1; e.addr = 32'h400;
    expq.push_back(e);
    step();
    rst = 1'b1; have_inst_i = 0;
    #1;
    chk("rst_req_drop", bus_req_o, 1'b0);
    chk("rst_stall_drop", stall_o, 1'b0);
    expq.push_back('{default: '0});
    step();
    rst = 1'b0;

    run_inst(MEM_NONE, 32'h55, 32'h0, 1'b1, 5'd10, 32'h58, 1'b1, 0, 32'h0);
    run_inst(MEM_LW, 32'h500, 32'h0, 1'b1, 5'd11, 32'h5C, 1'b1, 0, 32'hDEAD_BEEF);
    lit_wd_en = 1; lit_wd = 32'h1122_3344;
    run_inst(MEM_LW, 32'h504, 32'h0, 1'b1, 5'd12, 32'h60, 1'b1, 0, 32'h1122_3344);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 10);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[0] = 1'b0;
        if (op == 3 || op == 8) a[1] = 1'b0;
      end
      d = $urandom; rd = $urandom; pcv = $urandom; wr = 5'($urandom);
      rf = 1'($urandom); hv = ($urandom_range(0, 7) != 0);
      ack_d = $urandom_range(0, 5);
      run_inst(4'(op), a, d, rf, wr, pcv, hv, ack_d, rd);
    end

    have_inst_i = 0;
    step();
    step();
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
